// File: rtl/change_dispenser.sv
// Greedy change dispenser: plans coins one per cycle from inventory, then ejects them one per coin handshake.
// Latency N plan cycles + >=N eject cycles + 1 done cycle; coin_valid/coin_sel hold steady until coin_ready.
module change_dispenser #(
    parameter int COUNT_W    = 5,
    parameter int INIT_COUNT = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [7:0]         req_amount,
    output logic               req_ready,
    input  logic               dep_valid,
    input  logic [2:0]         dep_coin,
    output logic               coin_valid,
    output logic [2:0]         coin_sel,
    input  logic               coin_ready,
    output logic               done,
    output logic               ok,
    input  logic [2:0]         inv_sel,
    output logic [COUNT_W-1:0] inv_count
);
    typedef enum logic [2:0] {S_IDLE, S_PLAN, S_DISPENSE, S_DONE, S_FAIL} state_t;

    localparam int                 NCOIN    = 5;
    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_INIT = COUNT_W'(INIT_COUNT);

    function automatic logic [7:0] coin_value(input logic [2:0] code);
        case (code)
            3'd0:    coin_value = 8'd1;
            3'd1:    coin_value = 8'd2;
            3'd2:    coin_value = 8'd5;
            3'd3:    coin_value = 8'd10;
            3'd4:    coin_value = 8'd20;
            default: coin_value = 8'd0;
        endcase
    endfunction

    state_t             state;
    state_t             state_n;
    logic [7:0]         rem;
    logic [7:0]         rem_n;
    logic [COUNT_W-1:0] inv    [NCOIN];
    logic [COUNT_W-1:0] plan   [NCOIN];
    logic [COUNT_W-1:0] plan_n [NCOIN];
    logic               pick_vld;
    logic [2:0]         pick;
    logic [2:0]         sel_n;
    logic               plan_empty;
    logic               hs;
    logic [NCOIN-1:0]   dep_hit;
    logic [NCOIN-1:0]   dec;

    assign hs        = coin_valid && coin_ready;
    assign inv_count = (inv_sel < 3'd5) ? inv[inv_sel] : '0;

    // Ascending scan so the highest eligible denomination wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = 3'd0;
        for (int d = 0; d < NCOIN; d++) begin
            if (coin_value(3'(d)) <= rem && inv[d] > plan[d]) begin
                pick_vld = 1'b1;
                pick     = 3'(d);
            end
        end
    end

    always_comb begin
        for (int d = 0; d < NCOIN; d++) begin
            dep_hit[d] = dep_valid && (dep_coin == 3'(d));
            dec[d]     = hs && (coin_sel == 3'(d));
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        for (int d = 0; d < NCOIN; d++) plan_n[d] = plan[d];
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    rem_n = req_amount;
                    for (int d = 0; d < NCOIN; d++) plan_n[d] = '0;
                    state_n = (req_amount == 8'd0) ? S_DONE : S_PLAN;
                end
            end
            S_PLAN: begin
                if (pick_vld) begin
                    plan_n[pick] = plan[pick] + COUNT_W'(1);
                    rem_n        = rem - coin_value(pick);
                    if (rem == coin_value(pick)) state_n = S_DISPENSE;
                end else begin
                    state_n = S_FAIL;
                end
            end
            S_DISPENSE: begin
                if (hs) plan_n[coin_sel] = plan[coin_sel] - COUNT_W'(1);
            end
            default: state_n = S_IDLE;
        endcase

        sel_n      = 3'd0;
        plan_empty = 1'b1;
        for (int d = 0; d < NCOIN; d++) begin
            if (plan_n[d] != '0) begin
                sel_n      = 3'(d);
                plan_empty = 1'b0;
            end
        end
        if (state == S_DISPENSE && hs && plan_empty) state_n = S_DONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            rem        <= 8'd0;
            req_ready  <= 1'b1;
            coin_valid <= 1'b0;
            coin_sel   <= 3'd0;
            done       <= 1'b0;
            ok         <= 1'b0;
            for (int d = 0; d < NCOIN; d++) begin
                inv[d]  <= CNT_INIT;
                plan[d] <= '0;
            end
        end else begin
            state      <= state_n;
            rem        <= rem_n;
            req_ready  <= (state_n == S_IDLE);
            coin_valid <= (state_n == S_DISPENSE);
            coin_sel   <= sel_n;
            done       <= (state_n == S_DONE) || (state_n == S_FAIL);
            ok         <= (state_n == S_DONE);
            for (int d = 0; d < NCOIN; d++) begin
                plan[d] <= plan_n[d];
                // A deposit and an ejection of the same coin cancel, even when saturated.
                if (dec[d] && !dep_hit[d]) begin
                    inv[d] <= inv[d] - COUNT_W'(1);
                end else if (dep_hit[d] && !dec[d] && inv[d] != CNT_MAX) begin
                    inv[d] <= inv[d] + COUNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with hand-computed expectations.
`timescale 1ns/1ps
module tb_change_dispenser;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_amount = 8'd0;
    logic       req_ready;
    logic       dep_valid = 1'b0;
    logic [2:0] dep_coin = 3'd0;
    logic       coin_valid;
    logic [2:0] coin_sel;
    logic       coin_ready = 1'b1;
    logic       done;
    logic       ok;
    logic [2:0] inv_sel = 3'd0;
    logic [4:0] inv_count;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] coins[$];

    change_dispenser #(.COUNT_W(5), .INIT_COUNT(10)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .dep_valid(dep_valid), .dep_coin(dep_coin),
        .coin_valid(coin_valid), .coin_sel(coin_sel), .coin_ready(coin_ready),
        .done(done), .ok(ok),
        .inv_sel(inv_sel), .inv_count(inv_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic inv_is(input string tag, input logic [2:0] code, input int exp);
        inv_sel = code;
        #1;
        chk(tag, 32'(inv_count), exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Runs one request with coin_ready high; dep is deposited during the first PLAN cycle (7 = a note).
    task automatic do_req(input logic [7:0] amt, input logic [2:0] dep,
                          output int plan_cyc, output logic got_ok);
        int guard;
        req_amount = amt;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        dep_valid = 1'b1;
        dep_coin  = dep;
        coins.delete();
        plan_cyc = 0;
        guard    = 0;
        while (!coin_valid && !done && guard < 400) begin
            plan_cyc++;
            guard++;
            tick();
            dep_valid = 1'b0;
        end
        dep_valid = 1'b0;
        while (!done && guard < 400) begin
            if (coin_valid) coins.push_back(coin_sel);
            guard++;
            tick();
        end
        chk("req_done_seen", 32'(done), 1);
        got_ok = ok;
        tick();
    endtask

    function automatic logic [31:0] coin_at(input int i);
        if (i < coins.size()) return 32'(coins[i]);
        return 32'd7;
    endfunction

    initial begin
        int   pc;
        logic gok;
        int   guard;
        int   exp37 [4] = '{4, 3, 2, 1};
        int   inv37 [5] = '{10, 9, 9, 9, 9};

        do_reset();
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_coin_valid", 32'(coin_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ok", 32'(ok), 0);
        for (int c = 0; c < 5; c++) inv_is("rst_inv", 3'(c), 10);
        inv_is("inv_note_code", 3'd5, 0);

        // 37 = 20 + 10 + 5 + 2
        do_req(8'd37, 3'd7, pc, gok);
        chk("r37_plan_cycles", 32'(pc), 4);
        chk("r37_ncoins", 32'(coins.size()), 4);
        for (int i = 0; i < 4; i++) chk("r37_coin", coin_at(i), exp37[i]);
        chk("r37_ok", 32'(gok), 1);
        for (int c = 0; c < 5; c++) inv_is("r37_inv", 3'(c), inv37[c]);

        // exhaust the 5c coins
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_req(8'd1, 3'd7, pc, gok);
            chk("one_ok", 32'(gok), 1);
        end
        inv_is("one_inv0_empty", 3'd0, 0);
        do_req(8'd1, 3'd7, pc, gok);
        chk("one_fail_ok", 32'(gok), 0);
        chk("one_fail_ncoins", 32'(coins.size()), 0);
        inv_is("one_fail_inv0", 3'd0, 0);

        // greedy takes 25c leaving 1 unit, which cannot be paid
        do_req(8'd6, 3'd7, pc, gok);
        chk("r6_fail_ok", 32'(gok), 0);
        chk("r6_fail_ncoins", 32'(coins.size()), 0);
        chk("r6_fail_plan_cycles", 32'(pc), 2);
        inv_is("r6_fail_inv2", 3'd2, 10);

        // a 5c deposited in the first PLAN cycle completes the same plan
        do_req(8'd6, 3'd0, pc, gok);
        chk("r6_dep_ok", 32'(gok), 1);
        chk("r6_dep_ncoins", 32'(coins.size()), 2);
        chk("r6_dep_coin0", coin_at(0), 2);
        chk("r6_dep_coin1", coin_at(1), 0);
        inv_is("r6_dep_inv0", 3'd0, 0);
        inv_is("r6_dep_inv2", 3'd2, 9);

        // backpressure: hold coin_ready low, with a stray request that must be ignored
        do_reset();
        coin_ready = 1'b0;
        req_amount = 8'd20;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        req_amount = 8'd5;
        req_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(coin_valid), 1);
            chk("bp_sel", 32'(coin_sel), 4);
            inv_is("bp_inv4", 3'd4, 10);
            tick();
        end
        req_valid  = 1'b0;
        chk("bp_valid_last", 32'(coin_valid), 1);
        coin_ready = 1'b1;
        tick();
        chk("bp_done", 32'(done), 1);
        chk("bp_ok", 32'(ok), 1);
        chk("bp_valid_off", 32'(coin_valid), 0);
        inv_is("bp_inv4_after", 3'd4, 9);
        tick();
        chk("bp_idle_ready", 32'(req_ready), 1);
        chk("bp_no_second_req", 32'(done), 0);

        // deposit and ejection of the same coin in one cycle
        do_reset();
        coin_ready = 1'b0;
        req_amount = 8'd20;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        dep_valid  = 1'b1;
        dep_coin   = 3'd4;
        coin_ready = 1'b1;
        tick();
        dep_valid = 1'b0;
        chk("same_cycle_done", 32'(done), 1);
        inv_is("same_cycle_inv4", 3'd4, 10);
        tick();

        // saturation of the 5c counter; notes are ignored
        do_reset();
        dep_valid = 1'b1;
        dep_coin  = 3'd0;
        for (int i = 0; i < 25; i++) tick();
        dep_coin = 3'd5;
        tick();
        dep_valid = 1'b0;
        inv_is("sat_inv0", 3'd0, 31);
        inv_is("sat_inv1", 3'd1, 10);

        // reset in the middle of ejecting 255
        do_reset();
        req_amount = 8'd255;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        guard = 0;
        while (!coin_valid && guard < 100) begin
            guard++;
            tick();
        end
        chk("big_dispensing", 32'(coin_valid), 1);
        tick();
        tick();
        inv_is("big_inv4_mid", 3'd4, 8);
        reset = 1'b1;
        tick();
        chk("big_rst_valid", 32'(coin_valid), 0);
        chk("big_rst_done", 32'(done), 0);
        for (int c = 0; c < 5; c++) inv_is("big_rst_inv", 3'(c), 10);
        reset = 1'b0;
        chk("big_rel_ready", 32'(req_ready), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("big_no_done", 32'(done), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter COUNT_W, default 5: width of each coin inventory counter.
REQ-002 SHALL have parameter INIT_COUNT, default 10: per-denomination inventory after reset; must be at most 2^COUNT_W-1.
REQ-003 SHALL have port clock, input, 1, single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1, change request valid.
REQ-006 SHALL have port req_amount, input, 8, change amount in units of 5 centavos.
REQ-007 SHALL have port req_ready, output, 1, high only in IDLE.
REQ-008 SHALL have port dep_valid, input, 1, a coin was deposited by the customer.
REQ-009 SHALL have port dep_coin, input, 3, deposited code: 0=5c, 1=10c, 2=25c, 3=50c, 4=R$1; codes 5-7 are notes and are ignored.
REQ-010 SHALL have port coin_valid, output, 1, a coin is presented for ejection.
REQ-011 SHALL have port coin_sel, output, 3, denomination code (0-4) of the presented coin.
REQ-012 SHALL have port coin_ready, input, 1, ejector accepts the presented coin.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port ok, output, 1, valid with done: 1=change paid, 0=change impossible.
REQ-015 SHALL have port inv_sel, input, 3, inventory read select.
REQ-016 SHALL have port inv_count, output, COUNT_W, combinational inventory of denomination inv_sel; 0 for codes 5-7.

Function
REQ-017 SHALL use denomination values 20, 10, 5, 2, 1 units for codes 4, 3, 2, 1, 0.
REQ-018 SHALL implement states IDLE, PLAN, DISPENSE, DONE, FAIL.
REQ-019 IDLE: req_valid high -> latch req_amount into rem and clear all plan counters; next state is PLAN, or DONE when req_amount=0.
REQ-020 PLAN: each cycle, pick the highest code d with value(d)<=rem and inv(d)-plan(d)>0; increment plan(d) and subtract value(d) from rem.
REQ-021 PLAN: rem reaching 0 -> DISPENSE next cycle; rem>0 with no eligible d -> FAIL. Selection is greedy only; no backtracking.
REQ-022 DISPENSE: coin_valid=1 and coin_sel = highest code with plan>0.
REQ-023 DISPENSE: on a coin_valid & coin_ready cycle, decrement plan(coin_sel) and inv(coin_sel).
REQ-024 DISPENSE: after the last handshake -> DONE; coin_sel SHALL stay stable while coin_valid & !coin_ready.
REQ-025 DONE: done=1, ok=1 for one cycle, then IDLE.
REQ-026 FAIL: done=1, ok=0 for one cycle, then IDLE; inventory unchanged by the request.
REQ-027 Latency for a paid request of N coins: N PLAN cycles, at least N DISPENSE cycles, then 1 DONE cycle.
REQ-028 Deposits SHALL be accepted in every state: inv(dep_coin)+1, saturating at 2^COUNT_W-1.
REQ-029 A deposit and a dispense handshake on the same code in the same cycle SHALL leave that inventory unchanged.
REQ-030 Deposits made during PLAN SHALL be usable by the same plan.
REQ-031 req_valid outside IDLE SHALL be ignored.
REQ-032 coin_valid, done and ok SHALL be 0 in every state not listed above.

Reset
REQ-033 reset high at a clock edge SHALL force the following:
- state IDLE
- all inventories = INIT_COUNT
- plan counters and rem = 0
- coin_valid = 0, done = 0, ok = 0
REQ-034 reset SHALL take priority over deposits and handshakes, and SHALL abort any request mid-PLAN or mid-DISPENSE without a done pulse.
REQ-035 req_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-036 Reset, then request 37 -> 4 PLAN cycles; coins ejected with coin_sel 4, 3, 2, 1; done with ok=1; inventories codes 4..0 = 9, 9, 9, 9, 10.
REQ-037 Reset, then ten requests of 1 -> 5c inventory 0; an eleventh request of 1 -> done with ok=0, no coin_valid, inventory unchanged.
REQ-038 With 5c inventory at 0, request 6 -> greedy picks 25c, rem=1, FAIL; 25c inventory stays 10; ok=0.
REQ-039 Hold coin_ready low 3 cycles in DISPENSE -> coin_valid stays high, coin_sel stable, no inventory change; one handshake on release.
REQ-040 Deposit code 4 in the same cycle as a code-4 handshake -> inv(4) unchanged; 25 deposits of code 0 after reset -> inv(0)=31, saturated.
REQ-041 Assert reset mid-DISPENSE of request 255 -> coin_valid 0 next cycle, all inventories 10, no done pulse, req_ready 1 after release.
